// File: rtl/vga_capture_receiver.sv
// VGA loopback receiver: syncs pins, measures line/frame timing, locks, emits pixels + frame checksum.
// Pin-to-pixel latency 4 cycles; no backpressure, the pixel stream is free-running at the pixel clock.
module vga_capture_receiver #(
    parameter int CNT_W       = 12,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1,
    parameter int H_START     = 216,
    parameter int V_START     = 27,
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 600,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r,
    input  logic             g,
    input  logic             b,
    input  logic             hsync,
    input  logic             vsync,
    output logic             pixel_valid,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             pixel_r,
    output logic             pixel_g,
    output logic             pixel_b,
    output logic             locked,
    output logic             frame_done,
    output logic [15:0]      frame_checksum,
    output logic [CNT_W-1:0] line_length,
    output logic [CNT_W-1:0] frame_lines,
    output logic [CNT_W-1:0] hsync_width,
    output logic [7:0]       error_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LO    = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] H_HI    = CNT_W'(H_START + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_LO    = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] V_HI    = CNT_W'(V_START + V_ACTIVE);
    localparam logic [7:0]       LOCK_N  = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t               state;
    logic [4:0]           sync1, sync2, edge_q;   // {hs, vs, r, g, b}
    logic [CNT_W-1:0]     hcount, vcount, hsw_cnt;
    logic [7:0]           match_cnt;
    logic [2*CNT_W-1:0]   prev, meas;
    logic [CNT_W-1:0]     line_len_nxt;
    logic [15:0]          acc;
    logic [7:0]           err_inc;
    logic                 hs_lvl, hs_start, vs_start, h_sat, in_act;

    assign hs_lvl   = (sync2[4] == HS_POL);
    assign hs_start = hs_lvl && (edge_q[4] != HS_POL);
    assign vs_start = (sync2[3] == VS_POL) && (edge_q[3] != VS_POL);
    assign h_sat    = (hcount == CNT_MAX) && !hs_start;
    // Measurement of the frame just ending, including a coincident final line edge.
    assign line_len_nxt = hs_start ? hcount + ONE : line_length;
    assign meas         = {line_len_nxt, vcount + ONE};
    assign err_inc      = (error_count == 8'hFF) ? error_count : error_count + 8'd1;
    assign in_act       = (state == LOCKED) && (hcount >= H_LO) && (hcount < H_HI)
                          && (vcount >= V_LO) && (vcount < V_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            edge_q <= '0;
        end else begin
            sync1  <= {hsync, vsync, r, g, b};
            sync2  <= sync1;
            edge_q <= sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            hsw_cnt     <= '0;
            line_length <= '0;
            frame_lines <= '0;
            hsync_width <= '0;
        end else begin
            if (hs_start) begin
                line_length <= hcount + ONE;
                hsync_width <= hsw_cnt;
                hcount      <= '0;
                hsw_cnt     <= ONE;
            end else begin
                if (hcount != CNT_MAX)
                    hcount <= hcount + ONE;
                if (hs_lvl && hsw_cnt != CNT_MAX)
                    hsw_cnt <= hsw_cnt + ONE;
            end
            if (vs_start) begin
                frame_lines <= vcount + ONE;
                vcount      <= '0;
            end else if (hs_start && vcount != CNT_MAX) begin
                vcount <= vcount + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= SEARCH;
            match_cnt      <= '0;
            prev           <= '0;
            locked         <= 1'b0;
            frame_done     <= 1'b0;
            frame_checksum <= '0;
            error_count    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (h_sat) begin
                if (state == LOCKED)
                    error_count <= err_inc;
                state  <= SEARCH;
                locked <= 1'b0;
            end else if (vs_start) begin
                case (state)
                    SEARCH: begin
                        state     <= MEASURE;
                        match_cnt <= '0;
                        prev      <= '0;
                    end
                    MEASURE: begin
                        prev <= meas;
                        if (meas == prev && meas != '0) begin
                            match_cnt <= match_cnt + 8'd1;
                            if (match_cnt + 8'd1 >= LOCK_N) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (meas != prev) begin
                            state       <= SEARCH;
                            locked      <= 1'b0;
                            error_count <= err_inc;
                        end else begin
                            frame_done     <= 1'b1;
                            frame_checksum <= acc;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_r     <= 1'b0;
            pixel_g     <= 1'b0;
            pixel_b     <= 1'b0;
            acc         <= '0;
        end else begin
            pixel_valid <= in_act;
            pixel_x     <= in_act ? hcount - H_LO : '0;
            pixel_y     <= in_act ? vcount - V_LO : '0;
            pixel_r     <= in_act & edge_q[2];
            pixel_g     <= in_act & edge_q[1];
            pixel_b     <= in_act & edge_q[0];
            if (vs_start)
                acc <= '0;
            else if (pixel_valid)
                acc <= {acc[14:0], acc[15]} ^ {13'b0, pixel_r, pixel_g, pixel_b};
        end
    end
endmodule
